// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection, operand forwarding select and
// multiply/divide occupancy tracking for a classic five-stage pipeline.
// Optional feature macro: HAZARD_FORWARD_EN.
//   Defined:   EX operands forwarded from EX/MEM and MEM/WB; only load-use stalls.
//   Undefined: no forwarding (fwd_a/fwd_b = 00); any RAW against EX or MEM stalls.
module hazard_ctrl #(
  parameter int MD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_muldiv,
  input  logic        id_hilo_read,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic        ex_branch_taken,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        md_busy,
  output logic [15:0] stall_cycles
);

  localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES);

  logic [5:0] md_cnt;
  logic       dh;
  logic       sh;
  logic       md_start;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // A source matches a destination only when it is actually read, the
  // destination is actually written, and the register is not $0.
  function automatic logic reg_match(input logic [4:0] src, input logic used,
                                     input logic [4:0] dst, input logic wr);
    return used && wr && (src != 5'd0) && (src == dst);
  endfunction

  // Operand source select: EX/MEM (newest) wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (reg_match(src, 1'b1, mem_rd, mem_reg_write))
      return 2'b10;
    else if (reg_match(src, 1'b1, wb_rd, wb_reg_write))
      return 2'b01;
    else
      return 2'b00;
  endfunction

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be bypassed in time for the ID instruction.
  assign dh = reg_match(id_rs, id_use_rs, ex_rd, ex_mem_read)
            | reg_match(id_rt, id_use_rt, ex_rd, ex_mem_read);
  assign fwd_a_raw = fwd_sel(ex_rs);
  assign fwd_b_raw = fwd_sel(ex_rt);

  logic unused_inputs;
  assign unused_inputs = ex_reg_write;
`else
  // Without bypass paths every pending write in EX or MEM must drain; the
  // write-first register file covers the WB stage.
  assign dh = reg_match(id_rs, id_use_rs, ex_rd, ex_reg_write)
            | reg_match(id_rt, id_use_rt, ex_rd, ex_reg_write)
            | reg_match(id_rs, id_use_rs, mem_rd, mem_reg_write)
            | reg_match(id_rt, id_use_rt, mem_rd, mem_reg_write);
  assign fwd_a_raw = 2'b00;
  assign fwd_b_raw = 2'b00;

  logic unused_inputs;
  assign unused_inputs = ^{ex_rs, ex_rt, wb_rd, wb_reg_write, ex_mem_read,
                           fwd_sel(5'd0)};
`endif

  assign md_busy  = (md_cnt != 6'd0);
  assign sh       = md_busy && (id_muldiv || id_hilo_read);
  // A mult/div only issues when ID actually advances into EX.
  assign md_start = id_muldiv && !dh && !sh && !ex_branch_taken;

  // Pipeline control: a taken branch squashes the wrong-path instruction and
  // takes priority over any stall; everything is forced low during reset.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (!reset) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (dh || sh) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  // Multiply/divide occupancy: load on issue, count down to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= 6'd0;
    end else if (run) begin
      if (md_start)
        md_cnt <= MD_LOAD;
      else if (md_cnt != 6'd0)
        md_cnt <= md_cnt - 6'd1;
    end
  end

  // Saturating count of cycles in which the front end was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
    end else if (run && pc_hold && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven combinational checks plus hand-written
// multi-cycle sequences (load-use, mult/mflo interlock, async reset abort,
// no-forwarding double stall). Expectations follow HAZARD_FORWARD_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt, id_muldiv, id_hilo_read;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        ex_branch_taken;
  logic        pc_hold, ifid_hold, idex_bubble, ifid_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        md_busy;
  logic [15:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.MD_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .run(run),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_muldiv(id_muldiv), .id_hilo_read(id_hilo_read),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] id_rs, id_rt;
    logic       use_rs, use_rt;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ex_rw, ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic       br;
    logic [7:0] exp;  // {pc_hold, ifid_hold, idex_bubble, ifid_flush, fwd_a, fwd_b}
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(
      input logic [4:0] irs, input logic [4:0] irt, input logic urs, input logic urt,
      input logic [4:0] ers, input logic [4:0] ert, input logic [4:0] erd,
      input logic erw, input logic emr, input logic [4:0] mrd, input logic mrw,
      input logic [4:0] wrd, input logic wrw, input logic br,
      input logic h, input logic b, input logic f, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.id_rs = irs; v.id_rt = irt; v.use_rs = urs; v.use_rt = urt;
    v.ex_rs = ers; v.ex_rt = ert; v.ex_rd = erd; v.ex_rw = erw; v.ex_mr = emr;
    v.mem_rd = mrd; v.mem_rw = mrw; v.wb_rd = wrd; v.wb_rw = wrw; v.br = br;
    v.exp = {h, h, b, f, fa, fb};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end else begin
      $display("ok   %s: value=%0h", name, got);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_muldiv = 0; id_hilo_read = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    ex_branch_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] s0;
    int n;

    // ---------------- reset behaviour ----------------
    reset = 1'b1; run = 1'b1;
    clear_inputs();
    id_rs = 5'd2; id_use_rs = 1; ex_rd = 5'd2; ex_reg_write = 1; ex_mem_read = 1;
    ex_rs = 5'd3; mem_rd = 5'd3; mem_reg_write = 1;
    #12;
    chk("reset_ctrl_outputs", {24'd0, pc_hold, ifid_hold, idex_bubble, ifid_flush, fwd_a, fwd_b}, 32'd0);
    chk("reset_md_busy", {31'd0, md_busy}, 32'd0);
    chk("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table-driven combinational vectors (run=0) ----------------
    //            irs irt urs urt ers ert erd erw emr mrd mrw wrd wrw br  h   b   f   fa            fb
    vecs[0]  = mk(0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  2'b00,        2'b00);
    vecs[1]  = mk(2,  0,  1,  0,  0,  0,  2,  1,  1,  0,  0,  0,  0,  0,  1,  1,  0,  2'b00,        2'b00);
    vecs[2]  = mk(5,  2,  0,  1,  0,  0,  2,  1,  1,  0,  0,  0,  0,  0,  1,  1,  0,  2'b00,        2'b00);
    vecs[3]  = mk(2,  0,  0,  0,  0,  0,  2,  1,  1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b00,        2'b00);
    vecs[4]  = mk(4,  0,  1,  0,  0,  0,  4,  1,  0,  0,  0,  0,  0,  0,  !F, !F, 0,  2'b00,        2'b00);
    vecs[5]  = mk(0,  4,  0,  1,  4,  0,  0,  0,  0,  4,  1,  0,  0,  0,  !F, !F, 0,  F ? 2'b10 : 2'b00, 2'b00);
    vecs[6]  = mk(0,  0,  0,  0,  3,  0,  0,  0,  0,  3,  1,  3,  1,  0,  0,  0,  0,  F ? 2'b10 : 2'b00, 2'b00);
    vecs[7]  = mk(0,  0,  0,  0,  3,  0,  0,  0,  0,  3,  0,  3,  1,  0,  0,  0,  0,  F ? 2'b01 : 2'b00, 2'b00);
    vecs[8]  = mk(0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  1,  0,  0,  0,  0,  2'b00,        2'b00);
    vecs[9]  = mk(0,  0,  0,  0,  7,  7,  0,  0,  0,  7,  1,  7,  1,  0,  0,  0,  0,  F ? 2'b10 : 2'b00, F ? 2'b10 : 2'b00);
    vecs[10] = mk(0,  0,  0,  0,  0,  9,  0,  0,  0,  0,  0,  9,  1,  0,  0,  0,  0,  2'b00,        F ? 2'b01 : 2'b00);
    vecs[11] = mk(2,  0,  1,  0,  0,  0,  2,  1,  1,  0,  0,  0,  0,  1,  0,  1,  1,  2'b00,        2'b00);
    vecs[12] = mk(0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  1,  1,  2'b00,        2'b00);
    vecs[13] = mk(0,  0,  1,  1,  0,  0,  0,  1,  1,  0,  1,  0,  1,  0,  0,  0,  0,  2'b00,        2'b00);

    run = 1'b0;
    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt;
      id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
      ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt; ex_rd = vecs[i].ex_rd;
      ex_reg_write = vecs[i].ex_rw; ex_mem_read = vecs[i].ex_mr;
      mem_rd = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_rw;
      wb_rd = vecs[i].wb_rd; wb_reg_write = vecs[i].wb_rw;
      ex_branch_taken = vecs[i].br;
      step();
      chk($sformatf("vec%0d", i),
          {24'd0, pc_hold, ifid_hold, idex_bubble, ifid_flush, fwd_a, fwd_b},
          {24'd0, vecs[i].exp});
    end
    // Several held cycles passed with run=0: counter must not have moved.
    chk("run0_freezes_stall_cycles", {16'd0, stall_cycles}, 32'd0);

    // ---------------- load-use single stall ----------------
    clear_inputs();
    run = 1'b1;
    step();
    id_rs = 5'd2; id_use_rs = 1; ex_rd = 5'd2; ex_reg_write = 1; ex_mem_read = 1;
    #1;
    chk("loaduse_hold", {29'd0, pc_hold, ifid_hold, idex_bubble}, 32'b111);
    step();
    chk("loaduse_stall_cycles", {16'd0, stall_cycles}, 32'd1);
    clear_inputs();  // bubble now in EX, load in MEM (forwardable)
    ex_rs = 5'd2; mem_rd = 5'd2; mem_reg_write = 1;
    id_rs = 5'd2; id_use_rs = 1;
    #1;
    chk("loaduse_released", {31'd0, pc_hold}, {31'd0, !F});
    step();
    clear_inputs();
    step();
    chk("loaduse_stall_total", {16'd0, stall_cycles}, F ? 32'd1 : 32'd2);

    // ---------------- mult then mflo: 8-cycle interlock ----------------
    s0 = stall_cycles;
    clear_inputs();
    id_muldiv = 1;
    #1;
    chk("mult_accept_no_hold", {31'd0, pc_hold}, 32'd0);
    step();
    chk("mult_busy", {31'd0, md_busy}, 32'd1);
    // second mult while busy is a structural hazard
    #1;
    chk("mult_while_busy_hold", {31'd0, pc_hold}, 32'd1);
    id_muldiv = 0; id_hilo_read = 1;
    n = 0;
    while (pc_hold && n < 20) begin
      step();
      n++;
    end
    chk("mflo_stall_count", n, 32'd8);
    chk("mflo_released_busy", {31'd0, md_busy}, 32'd0);
    chk("mflo_stall_cycles_delta", {16'd0, stall_cycles - s0}, 32'd8);

    // ---------------- mult not issued under flush or load-use ----------------
    clear_inputs();
    id_muldiv = 1; ex_branch_taken = 1;
    step();
    chk("mult_blocked_by_flush", {31'd0, md_busy}, 32'd0);
    clear_inputs();
    id_muldiv = 1; id_rs = 5'd6; id_use_rs = 1; ex_rd = 5'd6; ex_reg_write = 1; ex_mem_read = 1;
    step();
    chk("mult_blocked_by_loaduse", {31'd0, md_busy}, 32'd0);

    // ---------------- run=0 freeze, then async reset abort ----------------
    clear_inputs();
    id_muldiv = 1;
    step();                        // counter = 8
    id_muldiv = 0; id_hilo_read = 1;
    s0 = stall_cycles;
    run = 1'b0;
    step(); step(); step();
    chk("run0_md_busy_held", {31'd0, md_busy}, 32'd1);
    chk("run0_stall_frozen", {16'd0, stall_cycles}, {16'd0, s0});
    chk("run0_comb_tracks", {31'd0, pc_hold}, 32'd1);
    run = 1'b1;
    step(); step(); step();        // counter 8 -> 5
    chk("pre_reset_busy", {31'd0, md_busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset_abort_md_busy", {31'd0, md_busy}, 32'd0);
    chk("reset_abort_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    chk("reset_abort_pc_hold", {31'd0, pc_hold}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after_reset_no_hold", {31'd0, pc_hold}, 32'd0);

    // ---------------- dependent add, EX then MEM ----------------
    clear_inputs();
    step();
    s0 = stall_cycles;
    id_rs = 5'd4; id_use_rs = 1; ex_rd = 5'd4; ex_reg_write = 1;
    step();
    ex_rd = 0; ex_reg_write = 0; mem_rd = 5'd4; mem_reg_write = 1;
    #1;
    chk("dep_add_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    step();
    mem_rd = 0; mem_reg_write = 0; wb_rd = 5'd4; wb_reg_write = 1;
    #1;
    chk("dep_add_released", {31'd0, pc_hold}, 32'd0);
    step();
    chk("dep_add_stall_delta", {16'd0, stall_cycles - s0}, F ? 32'd0 : 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
